cram_diag_loader: RTL and testbench

- Diagnostic-side initiator that writes one complete CRAM microword into a CRAM slice array over the diagnostic function bus.
- The word is written as a sequence of field-wide load functions (050+n). Optionally each field is read back over the EBUS using read functions (140+n) and compared.
- Sits between the DTE/console diagnostic controller and the crm slice boards. It is the transmitting/driving end of the load-func-05x / read-func-14x interface the slices respond to.

---
 rtl/cram_diag_loader_if.sv | 58 +++++
 rtl/cram_diag_loader.sv | 178 +++++++++++++++++
 tb/tb_cram_diag_loader.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cram_diag_loader_if.sv
// -----------------------------------------------------------------------------
// cram_diag_loader_if
// Groups the request/status handshake of the CRAM diagnostic loader together
// with the diagnostic function bus it drives toward the crm slice boards.
//
// Request handshake:
//   ld_req_h is a level request. It is accepted on any rising clock edge where
//   the loader is in IDLE (ld_busy_h low). Inputs ld_verify_h, ld_adr_h and
//   ld_word_h are captured on that same edge and may change freely afterwards.
//   Requests seen while ld_busy_h is high are dropped, not queued.
//   ld_done_h pulses for one cycle at the end, and ld_err_h/ld_err_field_h
//   stay valid until the next accept.
//
// Signals:
//   ld_req_h, ld_verify_h, ld_adr_h, ld_word_h : request side (into loader)
//   ld_busy_h, ld_done_h, ld_err_h, ld_err_field_h : status (out of loader)
//   diag_adr_h, diag_func_h, diag_strobe_h, diag_rd_h, diag_data_h :
//                                                  diag function bus (out)
//   ebus_d_h : read-back data from the selected slice field (into loader)
//   dbg_state_h : current FSM state code (out, debug only)
//
// Modports: master = the loader, slave = the controller/slice environment.
// -----------------------------------------------------------------------------
interface cram_diag_loader_if #(
   parameter int FIELDS  = 8,
   parameter int FIELD_W = 12,
   parameter int ADR_W   = 11
);
   logic                       ld_req_h;
   logic                       ld_verify_h;
   logic [ADR_W-1:0]           ld_adr_h;
   logic [FIELDS*FIELD_W-1:0]  ld_word_h;
   logic                       ld_busy_h;
   logic                       ld_done_h;
   logic                       ld_err_h;
   logic [2:0]                 ld_err_field_h;
   logic [ADR_W-1:0]           diag_adr_h;
   logic [6:0]                 diag_func_h;
   logic                       diag_strobe_h;
   logic                       diag_rd_h;
   logic [FIELD_W-1:0]         diag_data_h;
   logic [FIELD_W-1:0]         ebus_d_h;
   logic [3:0]                 dbg_state_h;

   modport master (
      input  ld_req_h, ld_verify_h, ld_adr_h, ld_word_h, ebus_d_h,
      output ld_busy_h, ld_done_h, ld_err_h, ld_err_field_h,
      output diag_adr_h, diag_func_h, diag_strobe_h, diag_rd_h, diag_data_h,
      output dbg_state_h
   );

   modport slave (
      output ld_req_h, ld_verify_h, ld_adr_h, ld_word_h, ebus_d_h,
      input  ld_busy_h, ld_done_h, ld_err_h, ld_err_field_h,
      input  diag_adr_h, diag_func_h, diag_strobe_h, diag_rd_h, diag_data_h,
      input  dbg_state_h
   );
endinterface

// File: rtl/cram_diag_loader.sv
// -----------------------------------------------------------------------------
// cram_diag_loader
// Diagnostic-side initiator that writes one CRAM microword into the slice
// array as a sequence of field-wide load functions (050+n), optionally reading
// each field back with read functions (140+n) and comparing against the word.
//
// Ports:
//   clk_dia_h   : diagnostic clock, all state on the rising edge
//   mr_reset_l  : asynchronous active-low reset, aborts any operation
//   bus         : cram_diag_loader_if.master (request/status + diag bus + EBUS)
//
// Per-field sequence: SETUP, STROBE (STB_W cycles), HOLD,
//   [RSETUP, RWAIT (RD_LAT cycles), RSAMPLE when verifying], NEXT.
// After the last field a single DONE cycle pulses ld_done_h.
// -----------------------------------------------------------------------------
module cram_diag_loader #(
   parameter int FIELDS  = 8,
   parameter int FIELD_W = 12,
   parameter int ADR_W   = 11,
   parameter int STB_W   = 2,
   parameter int RD_LAT  = 3
) (
   input  logic                clk_dia_h,
   input  logic                mr_reset_l,
   cram_diag_loader_if.master  bus
);

   localparam int IDX_W = 3;
   localparam int CNT_W = 4;

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_SETUP   = 4'd1;
   localparam logic [3:0] S_STROBE  = 4'd2;
   localparam logic [3:0] S_HOLD    = 4'd3;
   localparam logic [3:0] S_RSETUP  = 4'd4;
   localparam logic [3:0] S_RWAIT   = 4'd5;
   localparam logic [3:0] S_RSAMPLE = 4'd6;
   localparam logic [3:0] S_NEXT    = 4'd7;
   localparam logic [3:0] S_DONE    = 4'd8;

   localparam logic [IDX_W-1:0] LAST_N   = IDX_W'(FIELDS - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STB_W - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_LAT - 1);
   localparam logic [6:0]       F_LOAD   = 7'o050;
   localparam logic [6:0]       F_READ   = 7'o140;

   logic [3:0]                state_q, state_d;
   logic [IDX_W-1:0]          n_q, n_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [ADR_W-1:0]          adr_q, adr_d;
   logic [FIELDS*FIELD_W-1:0] word_q, word_d;
   logic                      verify_q, verify_d;
   logic                      err_q, err_d;
   logic [IDX_W-1:0]          err_field_q, err_field_d;
   logic [FIELD_W-1:0]        field_cur;

   assign field_cur = word_q[int'(n_q)*FIELD_W +: FIELD_W];

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      cnt_d       = cnt_q;
      adr_d       = adr_q;
      word_d      = word_q;
      verify_d    = verify_q;
      err_d       = err_q;
      err_field_d = err_field_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ld_req_h) begin
               adr_d       = bus.ld_adr_h;
               word_d      = bus.ld_word_h;
               verify_d    = bus.ld_verify_h;
               err_d       = 1'b0;
               err_field_d = '0;
               n_d         = '0;
               cnt_d       = '0;
               state_d     = S_SETUP;
            end
         end
         S_SETUP: begin
            cnt_d   = '0;
            state_d = S_STROBE;
         end
         S_STROBE: begin
            if (cnt_q == STB_LAST) state_d = S_HOLD;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         S_HOLD: begin
            state_d = verify_q ? S_RSETUP : S_NEXT;
         end
         S_RSETUP: begin
            cnt_d   = '0;
            state_d = S_RWAIT;
         end
         S_RWAIT: begin
            if (cnt_q == RD_LAST) state_d = S_RSAMPLE;
            else                  cnt_d   = cnt_q + 1'b1;
         end
         S_RSAMPLE: begin
            // Only the first mismatching field is recorded.
            if ((bus.ebus_d_h != field_cur) && !err_q) begin
               err_d       = 1'b1;
               err_field_d = n_q;
            end
            state_d = S_NEXT;
         end
         S_NEXT: begin
            if (n_q == LAST_N) begin
               state_d = S_DONE;
            end else begin
               n_d     = n_q + 1'b1;
               state_d = S_SETUP;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_dia_h or negedge mr_reset_l) begin
      if (!mr_reset_l) begin
         state_q     <= S_IDLE;
         n_q         <= '0;
         cnt_q       <= '0;
         adr_q       <= '0;
         word_q      <= '0;
         verify_q    <= 1'b0;
         err_q       <= 1'b0;
         err_field_q <= '0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         cnt_q       <= cnt_d;
         adr_q       <= adr_d;
         word_q      <= word_d;
         verify_q    <= verify_d;
         err_q       <= err_d;
         err_field_q <= err_field_d;
      end
   end

   // Bus outputs decoded from state; everything idles at zero so the slices
   // see a quiet bus outside an operation and immediately on reset.
   always_comb begin
      bus.diag_adr_h    = '0;
      bus.diag_func_h   = 7'o000;
      bus.diag_strobe_h = 1'b0;
      bus.diag_rd_h     = 1'b0;
      bus.diag_data_h   = '0;
      case (state_q)
         S_SETUP, S_STROBE, S_HOLD: begin
            bus.diag_adr_h    = adr_q;
            bus.diag_func_h   = F_LOAD + 7'(n_q);
            bus.diag_data_h   = field_cur;
            bus.diag_strobe_h = (state_q == S_STROBE);
         end
         S_RSETUP, S_RWAIT, S_RSAMPLE: begin
            bus.diag_adr_h  = adr_q;
            bus.diag_func_h = F_READ + 7'(n_q);
            bus.diag_data_h = field_cur;
            bus.diag_rd_h   = 1'b1;
         end
         S_NEXT:  bus.diag_adr_h = adr_q;
         default: ;
      endcase
   end

   always_comb begin
      bus.ld_busy_h      = (state_q != S_IDLE);
      bus.ld_done_h      = (state_q == S_DONE);
      bus.ld_err_h       = err_q;
      bus.ld_err_field_h = err_field_q;
      bus.dbg_state_h    = state_q;
   end

endmodule

// File: tb/tb_cram_diag_loader.sv
// -----------------------------------------------------------------------------
// tb_cram_diag_loader
// Bench for cram_diag_loader: a slice model captures strobed loads and returns
// them (optionally corrupted) on the EBUS RD_LAT cycles after a read function.
// Expected bus events and per-operation results are queued when a request is
// driven and consumed when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_cram_diag_loader;
   localparam int FIELDS  = 8;
   localparam int FIELD_W = 12;
   localparam int ADR_W   = 11;
   localparam int STB_W   = 2;
   localparam int RD_LAT  = 3;
   localparam int WW      = FIELDS * FIELD_W;
   localparam int EW      = 1 + ADR_W + 7 + FIELD_W;

   typedef struct {
      logic             verify;
      logic [ADR_W-1:0] adr;
      logic [WW-1:0]    word;
      logic [7:0]       corrupt;
      logic             exp_err;
      logic [2:0]       exp_field;
      int               exp_lat;
   } vec_t;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   cram_diag_loader_if #(.FIELDS(FIELDS), .FIELD_W(FIELD_W), .ADR_W(ADR_W)) bus ();

   cram_diag_loader #(
      .FIELDS(FIELDS), .FIELD_W(FIELD_W), .ADR_W(ADR_W),
      .STB_W(STB_W), .RD_LAT(RD_LAT)
   ) dut (
      .clk_dia_h  (clk),
      .mr_reset_l (rst_n),
      .bus        (bus)
   );

   // scoreboard state
   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int exp_done = 0;
   int rise_cyc = 0;
   logic [EW-1:0]      exp_q[$];
   logic [11:0]        op_q[$];
   logic [FIELD_W-1:0] slice_mem   [FIELDS] = '{default: '0};
   logic [FIELD_W-1:0] corrupt_mem [FIELDS] = '{default: '0};
   vec_t vecs [6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // slice EBUS model: read data appears RD_LAT cycles after the read function
   logic [6:0]         func_pipe [RD_LAT] = '{default: '0};
   logic [RD_LAT-1:0]  rd_pipe = '0;
   logic [FIELD_W-1:0] ebus_val;
   always @(posedge clk) begin
      rd_pipe <= {rd_pipe[RD_LAT-2:0], bus.diag_rd_h};
      func_pipe[0] <= bus.diag_func_h;
      for (int i = 1; i < RD_LAT; i++) func_pipe[i] <= func_pipe[i-1];
   end
   always_comb begin
      ebus_val = '0;
      if (rd_pipe[RD_LAT-1] && func_pipe[RD_LAT-1][6:3] == 4'b1100)
         ebus_val = slice_mem[func_pipe[RD_LAT-1][2:0]] ^ corrupt_mem[func_pipe[RD_LAT-1][2:0]];
   end
   assign bus.ebus_d_h = ebus_val;

   // monitor: consumes expected events, checks timing and results
   logic          prev_stb = 0, prev_rd = 0, prev_busy = 0, prev_done = 0;
   int            stb_len = 0;
   logic [EW-1:0] stb_snap, a_load, a_rd, e;
   logic [11:0]   op;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stb = 0; prev_rd = 0; prev_busy = 0; prev_done = 0; stb_len = 0;
      end else begin
         a_load = {1'b0, bus.diag_adr_h, bus.diag_func_h, bus.diag_data_h};
         a_rd   = {1'b1, bus.diag_adr_h, bus.diag_func_h, {FIELD_W{1'b0}}};
         if (bus.diag_strobe_h || bus.diag_rd_h)
            check("strobe_rd_exclusive", bus.diag_strobe_h & bus.diag_rd_h, 0);
         if (bus.diag_strobe_h && !prev_stb) begin
            check("load_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("load_event", a_load, e);
            end
            stb_snap = a_load;
            stb_len  = 0;
            if (bus.diag_func_h[6:3] == 4'b0101) slice_mem[bus.diag_func_h[2:0]] = bus.diag_data_h;
         end
         if (bus.diag_strobe_h) begin
            stb_len++;
            if (prev_stb) check("load_stable", a_load, stb_snap);
         end
         if (!bus.diag_strobe_h && prev_stb) check("strobe_width", stb_len, STB_W);
         if (bus.diag_rd_h && !prev_rd) begin
            check("read_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("read_event", a_rd, e);
            end
         end
         if (bus.ld_busy_h && !prev_busy) rise_cyc = cyc;
         if (bus.ld_done_h && !prev_done) begin
            done_cnt++;
            check("done_func_idle", bus.diag_func_h, 7'o000);
            check("done_all_events", exp_q.size(), 0);
            check("done_expected", op_q.size() != 0, 1);
            if (op_q.size() != 0) begin
               op = op_q.pop_front();
               // accept cycle is the one before busy rises
               check("done_latency", cyc - rise_cyc + 1, op[11:4]);
               check("done_err", bus.ld_err_h, op[3]);
               check("done_err_field", bus.ld_err_field_h, op[2:0]);
            end
         end
         prev_stb  = bus.diag_strobe_h;
         prev_rd   = bus.diag_rd_h;
         prev_busy = bus.ld_busy_h;
         prev_done = bus.ld_done_h;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string name);
      check(name, {bus.ld_busy_h, bus.ld_done_h, bus.ld_err_h, bus.ld_err_field_h,
                   bus.diag_adr_h, bus.diag_func_h, bus.diag_strobe_h, bus.diag_rd_h,
                   bus.diag_data_h}, 0);
   endtask

   task automatic push_op(input vec_t v);
      for (int n = 0; n < FIELDS; n++) begin
         exp_q.push_back({1'b0, v.adr, 7'o050 + 7'(n), v.word[n*FIELD_W +: FIELD_W]});
         if (v.verify) exp_q.push_back({1'b1, v.adr, 7'o140 + 7'(n), {FIELD_W{1'b0}}});
         corrupt_mem[n] = v.corrupt[n] ? 12'hA5A : 12'h000;
      end
      op_q.push_back({8'(v.exp_lat), v.exp_err, v.exp_field});
   endtask

   task automatic drive_inputs(input vec_t v);
      bus.ld_verify_h = v.verify;
      bus.ld_adr_h    = v.adr;
      bus.ld_word_h   = v.word;
   endtask

   task automatic apply_op(input vec_t v);
      push_op(v);
      drive_inputs(v);
      bus.ld_req_h = 1'b1;
      tick();
      bus.ld_req_h = 1'b0;
      exp_done++;
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (done_cnt < exp_done && k < 300) begin
         tick();
         k++;
      end
      check({name, "_timeout"}, k < 300, 1);
   endtask

   task automatic check_slices(input string name, input logic [WW-1:0] w);
      logic [WW-1:0] s;
      for (int n = 0; n < FIELDS; n++) s[n*FIELD_W +: FIELD_W] = slice_mem[n];
      check(name, s, w);
   endtask

   function automatic logic [WW-1:0] ramp_word();
      logic [WW-1:0] w;
      for (int k = 0; k < FIELDS; k++) w[k*FIELD_W +: FIELD_W] = 12'(k * 'h111);
      return w;
   endfunction

   function automatic logic [WW-1:0] rand_word();
      return {$urandom, $urandom, $urandom};
   endfunction

   function automatic vec_t mk(input logic ver, input logic [ADR_W-1:0] adr, input logic [WW-1:0] w,
                               input logic [7:0] cor, input logic err, input logic [2:0] fld);
      vec_t v;
      v.verify = ver; v.adr = adr; v.word = w; v.corrupt = cor;
      v.exp_err = err; v.exp_field = fld;
      v.exp_lat = ver ? 81 : 41;
      return v;
   endfunction

   initial begin
      vec_t v, v2;
      int   k;
      int   snap;
      bus.ld_req_h = 0; bus.ld_verify_h = 0; bus.ld_adr_h = '0; bus.ld_word_h = '0;

      // reset state
      #1;
      check_quiet("reset_outputs");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check_quiet("idle_outputs");

      // table-driven operations
      vecs[0] = mk(1'b0, 11'h2A5, ramp_word(), 8'h00, 1'b0, 3'd0);
      vecs[1] = mk(1'b1, 11'h123, ramp_word(), 8'h00, 1'b0, 3'd0);
      vecs[2] = mk(1'b1, 11'h2A5, ramp_word(), 8'b0010_0100, 1'b1, 3'd2);
      vecs[3] = mk(1'b0, 11'(  $urandom_range(0, 2047)), rand_word(), 8'hFF, 1'b0, 3'd0);
      vecs[4] = mk(1'b1, 11'h7FF, rand_word(), 8'h80, 1'b1, 3'd7);
      vecs[5] = mk(1'b1, 11'h000, rand_word(), 8'h81, 1'b1, 3'd0);
      for (int i = 0; i < 6; i++) begin
         apply_op(vecs[i]);
         wait_done("vec_done");
         check_slices("vec_slices", vecs[i].word);
         check("vec_idle_busy", bus.ld_busy_h, 0);
      end

      // reset during STROBE of field 3
      v = mk(1'b0, 11'h155, rand_word(), 8'h00, 1'b0, 3'd0);
      apply_op(v);
      exp_done--;
      k = 0;
      while (!(bus.diag_strobe_h && bus.diag_func_h == 7'o053) && k < 100) begin
         tick();
         k++;
      end
      check("rst_reach_field3", k < 100, 1);
      snap = done_cnt;
      rst_n = 1'b0;
      #1;
      check_quiet("rst_async_outputs");
      exp_q.delete();
      op_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) tick();
      check("rst_no_done", done_cnt, snap);
      check_quiet("rst_quiet_after");
      apply_op(vecs[1]);
      wait_done("rst_next_done");

      // request pulses and input changes mid-operation
      v = mk(1'b0, 11'(  $urandom_range(0, 2047)), rand_word(), 8'h00, 1'b0, 3'd0);
      apply_op(v);
      for (int i = 0; i < 30; i++) begin
         tick();
         bus.ld_req_h    = (i % 7 == 3);
         bus.ld_adr_h    = 11'($urandom);
         bus.ld_word_h   = rand_word();
         bus.ld_verify_h = 1'($urandom);
      end
      bus.ld_req_h = 1'b0;
      wait_done("pulse_done");
      check_slices("pulse_slices", v.word);
      check("pulse_done_count", done_cnt, exp_done);

      // request held high: back-to-back, second accept on first IDLE cycle
      v  = mk(1'b1, 11'h0F0, rand_word(), 8'h10, 1'b1, 3'd4);
      v2 = mk(1'b0, 11'h30F, ramp_word() ^ rand_word(), 8'h00, 1'b0, 3'd0);
      apply_op(v);
      bus.ld_req_h = 1'b1;
      k = 0;
      while (done_cnt < exp_done && k < 300) begin
         tick();
         k++;
         if (k == 6) begin
            bus.ld_adr_h  = 11'($urandom);
            bus.ld_word_h = rand_word();
         end
      end
      check("b2b_first_timeout", k < 300, 1);
      check("b2b_first_err", bus.ld_err_h, 1);
      push_op(v2);
      drive_inputs(v2);
      exp_done++;
      tick();
      bus.ld_req_h = 1'b0;
      check("b2b_accept_first_idle", bus.ld_busy_h, 1);
      check("b2b_err_cleared", bus.ld_err_h, 0);
      check("b2b_field_cleared", bus.ld_err_field_h, 0);
      wait_done("b2b_second_done");
      check_slices("b2b_slices", v2.word);

      // wrap-up
      repeat (3) tick();
      check("final_exp_q_empty", exp_q.size(), 0);
      check("final_op_q_empty", op_q.size(), 0);
      check("final_done_count", done_cnt, exp_done);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
